// File: rtl/oled_layer_arbiter_if.sv
// Bundles the oled pixel-request handshake, the two pixel-source ports and the
// requested overlay window of the layer arbiter.
interface oled_layer_arbiter_if;
  logic        read;
  logic [5:0]  row_idx;
  logic [6:0]  column_idx;
  logic [15:0] data_rgb;
  logic        ack;
  logic        read0;
  logic        read1;
  logic [5:0]  src_row_idx;
  logic [6:0]  src_column_idx;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        ack0;
  logic        ack1;
  logic [6:0]  win_x;
  logic [5:0]  win_y;
  logic        win_en;
  logic        frame_done;
  logic        timeout_flag;

  modport slave (
    input  read, row_idx, column_idx, data0, data1, ack0, ack1, win_x, win_y, win_en,
    output data_rgb, ack, read0, read1, src_row_idx, src_column_idx, frame_done, timeout_flag
  );

  modport master (
    output read, row_idx, column_idx, data0, data1, ack0, ack1, win_x, win_y, win_en,
    input  data_rgb, ack, read0, read1, src_row_idx, src_column_idx, frame_done, timeout_flag
  );
endinterface

// File: rtl/oled_layer_arbiter.sv
// Steers each oled pixel read to the background or overlay source, returns the
// reply, and substitutes a fallback colour when the selected source times out.
module oled_layer_arbiter #(
  parameter int          WIDTH    = 96,
  parameter int          HEIGHT   = 64,
  parameter int          WIN_W    = 16,
  parameter int          WIN_H    = 16,
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] FALLBACK = 16'hF81F
) (
  input logic             clk,
  input logic             reset,
  oled_layer_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    ax_q, ax_d;
  logic [5:0]    ay_q, ay_d;
  logic          aen_q, aen_d;
  logic [15:0]   data_q, data_d;
  logic          ack_q, ack_d;
  logic          read0_q, read0_d;
  logic          read1_q, read1_d;
  logic          frame_q, frame_d;
  logic          tflag_q, tflag_d;
  logic [5:0]    srow_q, srow_d;
  logic [6:0]    scol_q, scol_d;

  logic          first_px_s;
  logic [6:0]    cur_x_s;
  logic [5:0]    cur_y_s;
  logic          cur_en_s;
  logic [7:0]    col8_s, row8_s, x8_s, y8_s;
  logic          hit_s;
  logic          sel_ack_s;
  logic [15:0]   sel_data_s;

  // The frame's first pixel tests against the live window inputs; the rest use the latched copy.
  assign first_px_s = (bus.row_idx == 6'd0) && (bus.column_idx == 7'd0);
  assign cur_x_s    = first_px_s ? bus.win_x  : ax_q;
  assign cur_y_s    = first_px_s ? bus.win_y  : ay_q;
  assign cur_en_s   = first_px_s ? bus.win_en : aen_q;
  assign col8_s     = {1'b0, bus.column_idx};
  assign row8_s     = {2'b00, bus.row_idx};
  assign x8_s       = {1'b0, cur_x_s};
  assign y8_s       = {2'b00, cur_y_s};
  assign hit_s      = cur_en_s && (col8_s >= x8_s) && (col8_s < x8_s + 8'(WIN_W)) &&
                      (row8_s >= y8_s) && (row8_s < y8_s + 8'(WIN_H));
  assign sel_ack_s  = sel_q ? bus.ack1  : bus.ack0;
  assign sel_data_s = sel_q ? bus.data1 : bus.data0;

  // Next-state logic for the request/wait handshake.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    aen_d   = aen_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    read0_d = 1'b0;
    read1_d = 1'b0;
    frame_d = 1'b0;
    tflag_d = tflag_q;
    srow_d  = srow_q;
    scol_d  = scol_q;
    case (state_q)
      S_IDLE: begin
        if (bus.read) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          sel_d   = hit_s;
          last_d  = (bus.row_idx == 6'(HEIGHT - 1)) && (bus.column_idx == 7'(WIDTH - 1));
          read0_d = ~hit_s;
          read1_d = hit_s;
          if (hit_s) begin
            srow_d = bus.row_idx - cur_y_s;
            scol_d = bus.column_idx - cur_x_s;
          end else begin
            srow_d = bus.row_idx;
            scol_d = bus.column_idx;
          end
          if (first_px_s) begin
            ax_d  = bus.win_x;
            ay_d  = bus.win_y;
            aen_d = bus.win_en;
          end else begin
            aen_d = aen_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (sel_ack_s) begin
          state_d = S_IDLE;
          data_d  = sel_data_s;
          ack_d   = 1'b1;
          frame_d = last_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          data_d  = FALLBACK;
          ack_d   = 1'b1;
          frame_d = last_q;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ax_q    <= 7'd0;
      ay_q    <= 6'd0;
      aen_q   <= 1'b0;
      data_q  <= 16'd0;
      ack_q   <= 1'b0;
      read0_q <= 1'b0;
      read1_q <= 1'b0;
      frame_q <= 1'b0;
      tflag_q <= 1'b0;
      srow_q  <= 6'd0;
      scol_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      aen_q   <= aen_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      read0_q <= read0_d;
      read1_q <= read1_d;
      frame_q <= frame_d;
      tflag_q <= tflag_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
    end
  end

  assign bus.data_rgb       = data_q;
  assign bus.ack            = ack_q;
  assign bus.read0          = read0_q;
  assign bus.read1          = read1_q;
  assign bus.src_row_idx    = srow_q;
  assign bus.src_column_idx = scol_q;
  assign bus.frame_done     = frame_q;
  assign bus.timeout_flag   = tflag_q;
endmodule
